// File: rtl/img_mem_arbiter_pkg.sv
// img_pkg: image RAM geometry, requester indices and a modulo-3 helper
package img_pkg;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int addrSz = 15;
  localparam int colSz = 3;
  localparam int REQ_SCAN = 0;
  localparam int REQ_MAP = 1;
  localparam int REQ_CLEAN = 2;
  function automatic logic [1:0] wrap3(input int v);
    return 2'(v % 3);
  endfunction
endpackage

// File: rtl/img_mem_arbiter_if.sv
// img_mem_arbiter_if: requester-side handshake plus RAM-side port bundle
interface img_mem_arbiter_if #(
  parameter int addrSz = img_pkg::addrSz,
  parameter int colSz = img_pkg::colSz
);
  logic [2:0] req, lock, we, gnt, rvalid;
  logic [addrSz-1:0] addr0, addr1, addr2, mem_addr;
  logic [colSz-1:0] wdata0, wdata1, wdata2, rdata, mem_data, mem_q;
  logic err_oob, mem_wren;
  modport master(
    output req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_q,
    input gnt, rvalid, rdata, err_oob, mem_addr, mem_data, mem_wren
  );
  modport slave(
    input req, lock, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_q,
    output gnt, rvalid, rdata, err_oob, mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/img_mem_arbiter_rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker with lock override
module rr_pick3
  import img_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [1:0] lockOwner,
  input  logic       lockValid,
  output logic [2:0] gnt,
  output logic [1:0] win
);
  always_comb begin
    win = 2'd0;
    for (int k = 2; k >= 0; k--) win = req[wrap3(int'(ptr) + k)] ? wrap3(int'(ptr) + k) : win;
    win = (lockValid && req[lockOwner]) ? lockOwner : win;
    gnt = (|req) ? 3'b001 << win : 3'b000;
  end
endmodule

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: round-robin sharing of the image RAM between scanner, mappers and cleaner
module img_mem_arbiter #(
  parameter int addrSz = img_pkg::addrSz,
  parameter int colSz = img_pkg::colSz,
  parameter int DEPTH = img_pkg::DEPTH,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic resetn,
  img_mem_arbiter_if.slave bus
);
  localparam int cntW = $clog2(MAX_BURST + 1);
  logic [2:0] gntPick, tag0, tag1;
  logic [1:0] win, ptr, lockOwner;
  logic lockValid, oob0, oob1, oob, hit, weW, keep;
  logic [cntW-1:0] burstCnt, cntInc;
  logic [addrSz-1:0] addrW;
  logic [colSz-1:0] dataW;
  rr_pick3 picker (
    .req(bus.req), .ptr(ptr), .lockOwner(lockOwner), .lockValid(lockValid),
    .gnt(gntPick), .win(win)
  );
  always_comb begin
    addrW = win == 2'd0 ? bus.addr0 : win == 2'd1 ? bus.addr1 : bus.addr2;
    dataW = win == 2'd0 ? bus.wdata0 : win == 2'd1 ? bus.wdata1 : bus.wdata2;
    hit = |bus.req;
    weW = bus.we[win];
    oob = addrW >= addrSz'(DEPTH);
    cntInc = (lockValid && lockOwner == win) ? burstCnt + cntW'(1) : cntW'(1);
    keep = hit && bus.lock[win] && cntInc != cntW'(MAX_BURST);
  end
  assign bus.gnt = resetn ? gntPick : 3'b000;
  assign bus.rvalid = tag1;
  assign bus.rdata = (|tag1 && !oob1) ? bus.mem_q : '0;
  // a lock hold is re-armed each granted cycle until the burst limit forces one open arbitration
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
      lockOwner <= '0;
      lockValid <= 1'b0;
      burstCnt <= '0;
      tag0 <= '0;
      tag1 <= '0;
      oob0 <= 1'b0;
      oob1 <= 1'b0;
      bus.err_oob <= 1'b0;
      bus.mem_wren <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else begin
      tag0 <= (hit && !weW) ? gntPick : 3'b000;
      tag1 <= tag0;
      oob0 <= hit && oob;
      oob1 <= oob0;
      bus.mem_wren <= hit && weW && !oob;
      lockValid <= keep;
      lockOwner <= win;
      burstCnt <= keep ? cntInc : '0;
      if (hit) begin
        ptr <= img_pkg::wrap3(int'(win) + 1);
        bus.mem_addr <= addrW;
        bus.mem_data <= dataW;
        bus.err_oob <= bus.err_oob | oob;
      end
    end
  end
endmodule

// File: tb/tb_img_mem_arbiter.sv
// tb_img_mem_arbiter: scoreboard bench with a grant-order memory model and RAM behavioural model
module tb_img_mem_arbiter;
  import img_pkg::*;
  localparam int MB = 4;
  typedef struct { int who; int data; int due; } rd_t;
  logic clk = 1'b0, resetn = 1'b0;
  int checks = 0, errors = 0, cyc = 0;
  bit running = 1'b0;
  bit expErr = 1'b0;
  int gntQ[$];
  rd_t rdQ[$];
  rd_t mr;
  int refMem[DEPTH];
  logic [colSz-1:0] ram[32768];
  int aIn[3], dIn[3];
  int mStart = 0, mHold = -1, mRun = 0;
  always #5 clk = ~clk;
  img_mem_arbiter_if bus();
  img_mem_arbiter #(.MAX_BURST(MB)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= ram[bus.mem_addr];
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (running) begin
    if (gntQ.size() != 0) chk("gnt", int'(bus.gnt), gntQ.pop_front());
    chk("err_oob", int'(bus.err_oob), int'(expErr));
    if (bus.mem_wren) chk("wren_in_range", int'(bus.mem_addr < addrSz'(DEPTH)), 1);
    if (bus.rvalid != 3'b000) begin
      if (rdQ.size() == 0) chk("rvalid_unexpected", int'(bus.rvalid), 0);
      else begin
        mr = rdQ.pop_front();
        chk("rvalid", int'(bus.rvalid), 1 << mr.who);
        chk("rdata", int'(bus.rdata), mr.data);
        chk("rd_cycle", cyc, mr.due);
      end
    end else if (rdQ.size() != 0 && rdQ[0].due <= cyc) begin
      mr = rdQ.pop_front();
      chk("rvalid_missing", int'(bus.rvalid), 1 << mr.who);
    end
  end
  task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    bus.req = r;
    bus.lock = l;
    bus.we = w;
    bus.addr0 = addrSz'(aIn[0]);
    bus.addr1 = addrSz'(aIn[1]);
    bus.addr2 = addrSz'(aIn[2]);
    bus.wdata0 = colSz'(dIn[0]);
    bus.wdata1 = colSz'(dIn[1]);
    bus.wdata2 = colSz'(dIn[2]);
  endtask
  task automatic step(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
    int win;
    bit oobNow;
    drive(r, l, w);
    win = -1;
    if (mHold >= 0 && r[mHold]) win = mHold;
    else for (int k = 0; k < 3; k++) if (win < 0 && r[(mStart + k) % 3]) win = (mStart + k) % 3;
    oobNow = 1'b0;
    if (win < 0) begin
      mHold = -1;
      mRun = 0;
      gntQ.push_back(0);
    end else begin
      gntQ.push_back(1 << win);
      mStart = (win + 1) % 3;
      if (l[win]) begin
        mRun = (mHold == win) ? mRun + 1 : 1;
        mHold = (mRun == MB) ? -1 : win;
        if (mRun == MB) mRun = 0;
      end else begin
        mHold = -1;
        mRun = 0;
      end
      oobNow = aIn[win] >= DEPTH;
      if (!w[win]) rdQ.push_back('{win, oobNow ? 0 : refMem[aIn[win]], cyc + 2});
      else if (!oobNow) refMem[aIn[win]] = dIn[win];
    end
    @(posedge clk);
    #1;
    if (oobNow) expErr = 1'b1;
  endtask
  task automatic doReset(input logic [2:0] r);
    resetn = 1'b0;
    drive(r, 3'b000, 3'b000);
    gntQ.push_back(0);
    @(posedge clk);
    #1;
    rdQ.delete();
    mStart = 0;
    mHold = -1;
    mRun = 0;
    expErr = 1'b0;
    resetn = 1'b1;
    drive(3'b000, 3'b000, 3'b000);
    gntQ.push_back(0);
    @(negedge clk);
    chk("rst_rvalid", int'(bus.rvalid), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_mem_wren", int'(bus.mem_wren), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_data", int'(bus.mem_data), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic setAddr(input int a0, input int a1, input int a2);
    aIn[0] = a0;
    aIn[1] = a1;
    aIn[2] = a2;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i] = (i < DEPTH) ? colSz'($urandom_range(0, 7)) : 3'd7;
      if (i < DEPTH) refMem[i] = int'(ram[i]);
    end
    ram[100] = 3'd5;
    refMem[100] = 5;
    ram[200] = 3'd6;
    refMem[200] = 6;
    setAddr(0, 0, 0);
    dIn = '{0, 0, 0};
    drive(3'b000, 3'b000, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    running = 1'b1;
    doReset(3'b000);
    setAddr(100, 0, 0);
    step(3'b001, 3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    doReset(3'b000);
    setAddr(10, 11, 12);
    repeat (6) step(3'b111, 3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    setAddr(0, 0, 200);
    dIn = '{0, 0, 0};
    step(3'b100, 3'b000, 3'b100);
    setAddr(200, 0, 0);
    step(3'b001, 3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    doReset(3'b000);
    setAddr(20, 21, 22);
    repeat (9) step(3'b111, 3'b100, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    setAddr(0, DEPTH, 0);
    step(3'b010, 3'b000, 3'b000);
    setAddr(0, DEPTH + 1, 0);
    dIn = '{0, 7, 0};
    step(3'b010, 3'b000, 3'b010);
    repeat (4) step(3'b000, 3'b000, 3'b000);
    setAddr(5, 6, 7);
    step(3'b001, 3'b000, 3'b000);
    doReset(3'b111);
    step(3'b111, 3'b000, 3'b000);
    repeat (3) step(3'b000, 3'b000, 3'b000);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        aIn[i] = ($urandom_range(0, 31) == 0) ? int'($urandom_range(DEPTH, 32767)) : int'($urandom_range(0, 15));
        dIn[i] = int'($urandom_range(0, 7));
      end
      step(3'($urandom), 3'($urandom), 3'($urandom));
    end
    repeat (4) step(3'b000, 3'b000, 3'b000);
    running = 1'b0;
    chk("rd_queue_empty", rdQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
